// File: rtl/area_pkg.sv
// Shared scan definitions for the area scan generator and the per-node area-judge logic.
package area_pkg;

    localparam int COORD_W = 7;
    localparam logic [COORD_W-1:0] FIRST_ROW = 7'd1;
    localparam logic [COORD_W-1:0] FIRST_COL = 7'd0;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        GAP
    } scan_state_t;

endpackage

// File: rtl/area_coord_step.sv
// Next scan coordinate and end-of-frame flag. Raster order by default; the
// serpentine order (even rows descending) is built when SERPENTINE_SCAN_EN is defined.
module area_coord_step
    import area_pkg::*;
#(
    parameter int ROWS = 3,
    parameter int COLS = 8
) (
    input  logic [COORD_W-1:0] row_i,
    input  logic [COORD_W-1:0] col_i,
    output logic [COORD_W-1:0] row_o,
    output logic [COORD_W-1:0] col_o,
    output logic               last_o
);

    localparam logic [COORD_W-1:0] ROW_END = COORD_W'(ROWS);
    localparam logic [COORD_W-1:0] COL_END = COORD_W'(COLS - 1);
    localparam logic [COORD_W-1:0] ONE     = COORD_W'(1);

    always_comb begin
        row_o  = row_i;
        col_o  = col_i;
        last_o = 1'b0;
`ifdef SERPENTINE_SCAN_EN
        // Even rows run right-to-left; a row change keeps the column at the edge.
        if (!row_i[0]) begin
            if (col_i == FIRST_COL) begin
                last_o = (row_i == ROW_END);
                row_o  = row_i + ONE;
            end else begin
                col_o = col_i - ONE;
            end
        end else begin
            if (col_i == COL_END) begin
                last_o = (row_i == ROW_END);
                row_o  = row_i + ONE;
            end else begin
                col_o = col_i + ONE;
            end
        end
`else
        if (col_i == COL_END) begin
            last_o = (row_i == ROW_END);
            row_o  = row_i + ONE;
            col_o  = FIRST_COL;
        end else begin
            col_o = col_i + ONE;
        end
`endif
        if (last_o) begin
            row_o = FIRST_ROW;
            col_o = FIRST_COL;
        end
    end

endmodule

// File: rtl/area_scan_gen.sv
// Scan-position generator walking (row, col) over the LED grid with per-position dwell.
// Optional serpentine order via SERPENTINE_SCAN_EN (see area_coord_step).
//   state | meaning
//   IDLE  | no frame active, coordinates parked at (1,0)
//   SCAN  | live position driven, dwell counted while pos_ready
//   GAP   | blank cycles after the last position of a frame
module area_scan_gen
    import area_pkg::*;
#(
    parameter int ROWS    = 3,
    parameter int COLS    = 8,
    parameter int DWELL   = 4,
    parameter int GAP_CYC = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               continuous,
    input  logic               abort,
    input  logic               pos_ready,
    output logic [COORD_W-1:0] row_now,
    output logic [COORD_W-1:0] col_now,
    output logic               pos_valid,
    output logic               busy,
    output logic               frame_done
);

    localparam int DW = $clog2(DWELL + 1);
    localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [DW-1:0] DW_ONE     = DW'(1);
    localparam logic [GW-1:0] GAP_LOAD   = (GAP_CYC > 0) ? GW'(GAP_CYC - 1) : '0;
    localparam logic [GW-1:0] GW_ONE     = GW'(1);

    scan_state_t        state_q, state_d;
    logic [COORD_W-1:0] row_q, row_d;
    logic [COORD_W-1:0] col_q, col_d;
    logic [DW-1:0]      dwell_q, dwell_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic               done_q, done_d;

    logic [COORD_W-1:0] nxt_row;
    logic [COORD_W-1:0] nxt_col;
    logic               nxt_last;

    area_coord_step #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_step (
        .row_i  (row_q),
        .col_i  (col_q),
        .row_o  (nxt_row),
        .col_o  (nxt_col),
        .last_o (nxt_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= FIRST_ROW;
            col_q   <= FIRST_COL;
            dwell_q <= '0;
            gap_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            dwell_q <= dwell_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        dwell_d = dwell_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    row_d   = FIRST_ROW;
                    col_d   = FIRST_COL;
                    dwell_d = '0;
                end
            end
            SCAN: begin
                if (pos_ready) begin
                    if (dwell_q == DWELL_LAST) begin
                        dwell_d = '0;
                        row_d   = nxt_row;
                        col_d   = nxt_col;
                        if (nxt_last) begin
                            if (GAP_CYC > 0) begin
                                state_d = GAP;
                                gap_d   = GAP_LOAD;
                            end else if (!continuous) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                        end
                    end else begin
                        dwell_d = dwell_q + DW_ONE;
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    if (continuous) begin
                        state_d = SCAN;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    gap_d = gap_q - GW_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
        // abort wins over start, advance and frame-end in the same cycle
        if (abort) begin
            state_d = IDLE;
            row_d   = FIRST_ROW;
            col_d   = FIRST_COL;
            dwell_d = '0;
            gap_d   = '0;
            done_d  = 1'b0;
        end
    end

    assign row_now    = row_q;
    assign col_now    = col_q;
    assign pos_valid  = (state_q == SCAN);
    assign busy       = (state_q != IDLE);
    assign frame_done = done_q;

endmodule

// File: tb/tb_area_scan_gen.sv
// Scoreboard bench for area_scan_gen: a 3x4 grid (dwell 2, gap 2) plus a 2x4 grid (dwell 1, no gap).
module tb_area_scan_gen;

    localparam int R  = 3;
    localparam int C  = 4;
    localparam int D  = 2;
    localparam int G  = 2;
    localparam int RB = 2;
    localparam int CB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, continuous, abort, pos_ready;
    logic [6:0] row_now, col_now;
    logic       pos_valid, busy, frame_done;

    logic       start_b, cont_b, abort_b, ready_b;
    logic [6:0] row_b, col_b;
    logic       valid_b, busy_b, done_b;

    area_scan_gen #(.ROWS(R), .COLS(C), .DWELL(D), .GAP_CYC(G)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
        .abort(abort), .pos_ready(pos_ready), .row_now(row_now), .col_now(col_now),
        .pos_valid(pos_valid), .busy(busy), .frame_done(frame_done)
    );

    area_scan_gen #(.ROWS(RB), .COLS(CB), .DWELL(1), .GAP_CYC(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .continuous(cont_b),
        .abort(abort_b), .pos_ready(ready_b), .row_now(row_b), .col_now(col_b),
        .pos_valid(valid_b), .busy(busy_b), .frame_done(done_b)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [13:0] sb[$];
    int          done_cnt, judge_cnt, hold_cnt, gap_cnt;
    logic        seen_done, obs_valid;
    logic [6:0]  obs_row, obs_col;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] exp_pos(input int idx, input int cols);
        int r;
        int c;
        r = idx / cols;
        c = idx % cols;
`ifdef SERPENTINE_SCAN_EN
        if (r % 2 == 1) c = cols - 1 - c;
`endif
        return {7'(r + 1), 7'(c)};
    endfunction

    task automatic push_frame();
        for (int i = 0; i < R * C; i++)
            for (int d = 0; d < D; d++)
                sb.push_back(exp_pos(i, C));
    endtask

    task automatic clr();
        done_cnt  = 0;
        judge_cnt = 0;
        hold_cnt  = 0;
        gap_cnt   = 0;
        seen_done = 1'b0;
        sb.delete();
    endtask

    // Observe outputs mid-cycle, together with the inputs the next edge will sample.
    task automatic mon();
        seen_done = frame_done;
        obs_valid = pos_valid;
        obs_row   = row_now;
        obs_col   = col_now;
        if (frame_done) done_cnt++;
        if (pos_valid) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", sb.size() != 0, 1);
            end else begin
                chk("pos", {row_now, col_now}, sb[0]);
                if (pos_ready) void'(sb.pop_front());
            end
            if (row_now == 7'd1 && col_now == 7'd2) judge_cnt++;
            if (row_now == 7'd2 && col_now == 7'd1) hold_cnt++;
        end else if (busy) begin
            gap_cnt++;
            chk("gap_coord", {row_now, col_now}, {7'd1, 7'd0});
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int k);
        k = 0;
        seen_done = 1'b0;
        while (!seen_done && k < limit) begin
            cyc();
            k++;
        end
        chk("done_seen", seen_done, 1);
    endtask

    task automatic wait_pos(input logic [6:0] r, input logic [6:0] c, input int limit);
        int k;
        logic found;
        k = 0;
        found = 1'b0;
        while (!found && k < limit) begin
            cyc();
            k++;
            found = obs_valid && obs_row == r && obs_col == c;
        end
        chk("reach_pos", found, 1);
    endtask

    initial begin
        int k;
        rst_n = 1'b1;
        start = 1'b0; continuous = 1'b0; abort = 1'b0; pos_ready = 1'b1;
        start_b = 1'b0; cont_b = 1'b0; abort_b = 1'b0; ready_b = 1'b1;
        clr();
        #2 rst_n = 1'b0;
        #8;
        chk("rst_row", row_now, 1);
        chk("rst_col", col_now, 0);
        chk("rst_valid", pos_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // single frame, ready held high
        clr();
        push_frame();
        pulse_start();
        wait_done(60, k);
        chk("done_cycle", k, R * C * D + G + 1);
        chk("sb_drained", sb.size(), 0);
        chk("judge1_cycles", judge_cnt, D);
        chk("gap_cycles", gap_cnt, G);
        cyc();
        cyc();
        chk("done_pulses", done_cnt, 1);
        chk("idle_after", busy, 0);

        // backpressure at (2,1)
        clr();
        push_frame();
        pulse_start();
        wait_pos(7'd2, 7'd1, 40);
        pos_ready = 1'b0;
        repeat (5) cyc();
        pos_ready = 1'b1;
        wait_done(80, k);
        chk("bp_hold", hold_cnt, 7);
        chk("bp_drained", sb.size(), 0);
        chk("bp_done_pulses", done_cnt, 1);

        // continuous, cleared during the second frame
        clr();
        continuous = 1'b1;
        push_frame();
        push_frame();
        pulse_start();
        k = 0;
        while (!seen_done && k < 120) begin
            cyc();
            k++;
            if (sb.size() < R * C * D / 2) continuous = 1'b0;
        end
        chk("cont_done_cycle", k, 2 * (R * C * D + G) + 1);
        chk("cont_done_pulses", done_cnt, 1);
        chk("cont_gap_cycles", gap_cnt, 2 * G);
        chk("cont_drained", sb.size(), 0);
        continuous = 1'b0;

        // abort together with start at (2,2)
        clr();
        push_frame();
        pulse_start();
        wait_pos(7'd2, 7'd2, 40);
        abort = 1'b1;
        start = 1'b1;
        cyc();
        abort = 1'b0;
        start = 1'b0;
        sb.delete();
        chk("abort_valid", pos_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_coord", {row_now, col_now}, {7'd1, 7'd0});
        chk("abort_done", frame_done, 0);
        repeat (3) cyc();
        chk("abort_stay_idle", busy, 0);
        chk("abort_no_done", done_cnt, 0);
        push_frame();
        pulse_start();
        wait_done(60, k);
        chk("restart_done_cycle", k, R * C * D + G + 1);
        chk("restart_drained", sb.size(), 0);

        // asynchronous reset mid-dwell at (3,1)
        clr();
        push_frame();
        pulse_start();
        wait_pos(7'd3, 7'd1, 60);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_row", row_now, 1);
        chk("arst_col", col_now, 0);
        chk("arst_valid", pos_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", frame_done, 0);
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) cyc();
        chk("arst_stay_idle", busy, 0);
        chk("arst_no_valid", pos_valid, 0);

        // 2x4 grid, dwell 1, no gap: single shot
        start_b = 1'b1;
        cyc();
        start_b = 1'b0;
        for (int i = 0; i < RB * CB; i++) begin
            chk("b_pos", {row_b, col_b}, exp_pos(i, CB));
            chk("b_valid", valid_b, 1);
            cyc();
        end
        chk("b_done", done_b, 1);
        chk("b_busy", busy_b, 0);
        cyc();
        chk("b_done_pulse", done_b, 0);

        // 2x4 grid continuous: restart with no blank cycle
        cont_b = 1'b1;
        start_b = 1'b1;
        cyc();
        start_b = 1'b0;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < RB * CB; i++) begin
                if (f == 1 && i == 3) cont_b = 1'b0;
                chk("bc_pos", {row_b, col_b}, exp_pos(i, CB));
                chk("bc_no_done", done_b, 0);
                cyc();
            end
        end
        chk("bc_done", done_b, 1);
        chk("bc_valid", valid_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
